// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: issues one memory read at the current PC, hands the word to
// decode with valid/ready and drives the PC register update (PC+PC_STEP or redirect target).
module fetch_unit #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] pc_next,
    output logic              pc_we,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    input  logic              mem_rsp_valid,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr_data,
    output logic [ADDR_W-1:0] instr_pc
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_OUT  = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_drop;
    logic              w_drop_next;
    logic [DATA_W-1:0] r_instr_data;
    logic [ADDR_W-1:0] r_instr_pc;
    logic              w_capture_pc;
    logic              w_capture_data;
    logic              w_pc_we;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_req_valid;
    logic [ADDR_W-1:0] w_req_addr;
    logic              w_instr_valid;

    // State, drop flag and captured instruction registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_drop       <= 1'b0;
            r_instr_data <= {DATA_W{1'b0}};
            r_instr_pc   <= {ADDR_W{1'b0}};
        end else begin
            r_state <= w_state_next;
            r_drop  <= w_drop_next;
            if (w_capture_pc) begin
                r_instr_pc <= pc_in;
            end
            if (w_capture_data) begin
                r_instr_data <= mem_rsp_data;
            end
        end
    end

    // Next-state, PC update and handshake decode; redirect outranks the sequential increment
    always_comb begin
        w_state_next   = r_state;
        w_drop_next    = r_drop;
        w_capture_pc   = 1'b0;
        w_capture_data = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_next      = {ADDR_W{1'b0}};
        w_req_valid    = 1'b0;
        w_req_addr     = {ADDR_W{1'b0}};
        w_instr_valid  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state_next = S_REQ;
            end
            S_REQ: begin
                w_req_valid = 1'b1;
                w_req_addr  = pc_in;
                if (redirect) begin
                    w_pc_we   = 1'b1;
                    w_pc_next = redirect_pc;
                    if (mem_req_ready) begin
                        // request already left with the old PC; its data must be thrown away
                        w_drop_next  = 1'b1;
                        w_state_next = S_WAIT;
                    end else begin
                        w_state_next = S_REQ;
                    end
                end else if (mem_req_ready) begin
                    w_capture_pc = 1'b1;
                    w_state_next = S_WAIT;
                end else begin
                    w_state_next = S_REQ;
                end
            end
            S_WAIT: begin
                if (redirect) begin
                    w_pc_we   = 1'b1;
                    w_pc_next = redirect_pc;
                    if (mem_rsp_valid) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_drop_next  = 1'b1;
                        w_state_next = S_WAIT;
                    end
                end else if (mem_rsp_valid) begin
                    if (r_drop) begin
                        w_drop_next  = 1'b0;
                        w_state_next = S_REQ;
                    end else begin
                        w_capture_data = 1'b1;
                        w_pc_we        = 1'b1;
                        w_pc_next      = r_instr_pc + ADDR_W'(PC_STEP);
                        w_state_next   = S_OUT;
                    end
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            S_OUT: begin
                if (redirect) begin
                    w_pc_we      = 1'b1;
                    w_pc_next    = redirect_pc;
                    w_state_next = S_REQ;
                end else begin
                    w_instr_valid = 1'b1;
                    if (instr_ready) begin
                        w_state_next = S_REQ;
                    end else begin
                        w_state_next = S_OUT;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_drop_next  = 1'b0;
            end
        endcase
    end

    // Output stage: everything held at zero while reset is asserted
    always_comb begin
        if (reset) begin
            pc_we         = 1'b0;
            pc_next       = {ADDR_W{1'b0}};
            mem_req_valid = 1'b0;
            mem_req_addr  = {ADDR_W{1'b0}};
            instr_valid   = 1'b0;
            instr_data    = {DATA_W{1'b0}};
            instr_pc      = {ADDR_W{1'b0}};
        end else begin
            pc_we         = w_pc_we;
            pc_next       = w_pc_next;
            mem_req_valid = w_req_valid;
            mem_req_addr  = w_req_addr;
            instr_valid   = w_instr_valid;
            instr_data    = r_instr_data;
            instr_pc      = r_instr_pc;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models the PC register and a latency-configurable memory around the
// DUT; expected requests and instructions are queued by the stimulus and checked by monitors.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_we;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } instr_t;

    instr_t      q_instr[$];
    logic [31:0] q_addr[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    int          we_cnt = 0;
    int          lat = 1;
    logic [31:0] pc_rst_val = 32'h0;

    always #5 clk = ~clk;

    fetch_unit #(.ADDR_W(32), .DATA_W(32), .PC_STEP(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .pc_we        (pc_we),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_addr (mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_data (mem_rsp_data),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .instr_data   (instr_data),
        .instr_pc     (instr_pc)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // PC register model: sample write strobe mid-cycle, update just after the edge
    initial begin
        logic        s_we;
        logic        s_rst;
        logic [31:0] s_nx;
        pc_in = 32'h0;
        forever begin
            @(negedge clk);
            s_we  = pc_we;
            s_nx  = pc_next;
            s_rst = reset;
            @(posedge clk);
            #1;
            if (s_rst) pc_in = pc_rst_val;
            else if (s_we) pc_in = s_nx;
            if (s_we) we_cnt++;
        end
    end

    // Memory model: one response 'lat' cycles after accept, data = addr ^ A5A5A5A5
    initial begin
        logic        acc_s;
        logic [31:0] acc_addr_s;
        logic [31:0] pend_addr;
        bit          pend;
        int          cnt;
        pend = 1'b0;
        cnt = 0;
        pend_addr = 32'h0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = 32'h0;
        forever begin
            @(negedge clk);
            acc_s      = mem_req_valid && mem_req_ready;
            acc_addr_s = mem_req_addr;
            @(posedge clk);
            #1;
            mem_rsp_valid = 1'b0;
            if (acc_s) begin
                check("single_outstanding", 32'(pend), 32'h0);
                if (q_addr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL req_unexpected: got request at %h, required none", acc_addr_s);
                end else begin
                    check("req_addr", acc_addr_s, q_addr[0]);
                    void'(q_addr.pop_front());
                end
                pend = 1'b1;
                cnt = lat;
                pend_addr = acc_addr_s;
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = pend_addr ^ 32'hA5A5A5A5;
                    pend = 1'b0;
                end
            end
        end
    end

    // Instruction monitor: every valid cycle is checked against the queue head
    initial begin
        forever begin
            @(negedge clk);
            if (instr_valid) begin
                if (q_instr.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL instr_unexpected: got pc %h data %h, required no instruction",
                             instr_pc, instr_data);
                end else begin
                    check("instr_pc", instr_pc, q_instr[0].pc);
                    check("instr_data", instr_data, q_instr[0].data);
                    if (instr_ready && !redirect) void'(q_instr.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_one();
        int i;
        mem_req_ready = 1'b1;
        for (i = 0; i < 40 && !mem_req_valid; i++) cyc();
        check("req_timeout", 32'(mem_req_valid), 32'h1);
        cyc();
        mem_req_ready = 1'b0;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 60 && q_instr.size() != 0; i++) cyc();
        check("drain_timeout", q_instr.size(), 32'h0);
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] d);
        instr_t e;
        e.pc = a;
        e.data = d;
        q_instr.push_back(e);
    endtask

    initial begin
        logic [31:0] t1_data[4];
        t1_data = '{32'hA5A5A5A5, 32'hA5A5A5A1, 32'hA5A5A5AD, 32'hA5A5A5A9};
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = 32'h0;
        mem_req_ready = 1'b0;
        instr_ready = 1'b1;
        repeat (2) cyc();
        @(negedge clk);
        check("rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("rst_instr_valid", 32'(instr_valid), 32'h0);
        check("rst_pc_we", 32'(pc_we), 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_data", instr_data, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        we_cnt = 0;

        // sequential fetch 0,4,8,12
        for (int k = 0; k < 4; k++) begin
            q_addr.push_back(32'(k * 4));
            push(32'(k * 4), t1_data[k]);
            issue_one();
            wait_drain();
        end
        check("t1_pc_we_count", 32'(we_cnt), 32'h4);
        check("t1_pc", pc_in, 32'h10);

        // decode stall in OUT
        instr_ready = 1'b0;
        q_addr.push_back(32'h10);
        push(32'h10, 32'hA5A5A5B5);
        issue_one();
        for (int i = 0; i < 20 && !instr_valid; i++) cyc();
        check("t2_valid_seen", 32'(instr_valid), 32'h1);
        repeat (5) cyc();
        check("t2_valid_held", 32'(instr_valid), 32'h1);
        check("t2_no_req", 32'(mem_req_valid), 32'h0);
        instr_ready = 1'b1;
        wait_drain();

        // redirect while waiting for a slow response
        lat = 3;
        q_addr.push_back(32'h14);
        q_addr.push_back(32'h100);
        push(32'h100, 32'hA5A5A4A5);
        issue_one();
        redirect = 1'b1;
        redirect_pc = 32'h100;
        cyc();
        redirect = 1'b0;
        issue_one();
        wait_drain();
        check("t3_pc", pc_in, 32'h104);

        // redirect kills the instruction being presented
        lat = 1;
        q_addr.push_back(32'h104);
        q_addr.push_back(32'h40);
        issue_one();
        cyc();
        redirect = 1'b1;
        redirect_pc = 32'h40;
        instr_ready = 1'b1;
        #2;
        check("t4_kill_valid", 32'(instr_valid), 32'h0);
        check("t4_pc_we", 32'(pc_we), 32'h1);
        check("t4_pc_next", pc_next, 32'h40);
        cyc();
        redirect = 1'b0;
        push(32'h40, 32'hA5A5A5E5);
        issue_one();
        wait_drain();
        check("t4_pc", pc_in, 32'h44);

        // PC wrap at top of address space
        pc_rst_val = 32'hFFFFFFFC;
        reset = 1'b1;
        repeat (2) cyc();
        reset = 1'b0;
        q_addr.push_back(32'hFFFFFFFC);
        push(32'hFFFFFFFC, 32'h5A5A5A59);
        issue_one();
        #2;
        check("t5_pc_we", 32'(pc_we), 32'h1);
        check("t5_pc_next_wrap", pc_next, 32'h0);
        wait_drain();
        check("t5_pc", pc_in, 32'h0);

        // reset while a response is outstanding
        pc_rst_val = 32'h0;
        lat = 3;
        q_addr.push_back(32'h0);
        issue_one();
        reset = 1'b1;
        @(negedge clk);
        check("t6_rst_req_valid", 32'(mem_req_valid), 32'h0);
        check("t6_rst_pc_we", 32'(pc_we), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) cyc();
        check("t6_stale_ignored", 32'(instr_valid), 32'h0);
        check("t6_restart_addr", mem_req_addr, 32'h0);
        lat = 1;
        q_addr.push_back(32'h0);
        push(32'h0, 32'hA5A5A5A5);
        issue_one();
        wait_drain();

        repeat (3) cyc();
        check("end_addr_queue", q_addr.size(), 32'h0);
        check("end_instr_queue", q_instr.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
